// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared FSM state encodings, index-width and wdata slice helpers for dff_bank_arbiter.
package dff_arb_pkg;
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, HOLD = 2'd2;
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
    function automatic int slice_lo(input int i, input int width);
        return i * width;
    endfunction
endpackage

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester-side bus of the shared register arbiter.
//   req/wdata/clr driven by requesters (master); gnt/Q/owner/valid/busy driven by the arbiter (slave).
interface dff_bank_arbiter_if import dff_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IW = idx_w(NUM_REQ);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic                     clr;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         Q;
    logic [IW-1:0]            owner;
    logic                     valid;
    logic                     busy;
    modport master(output req, wdata, clr, input gnt, Q, owner, valid, busy);
    modport slave(input req, wdata, clr, output gnt, Q, owner, valid, busy);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req: request vector; ptr: last-granted index; winner: first set req above ptr (wrapping); any_req: |req.
module rr_picker import dff_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any_req
);
    logic [IW-1:0] j;
    assign any_req = |req;
    // Scan from the farthest candidate back to ptr+1 so the nearest set bit is the last one kept.
    always_comb begin
        winner = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) winner = j;
        end
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbitrated single writer of a shared WIDTH-bit register.
//   CLK: clock; reset: async active-low; bus: slave side of dff_bank_arbiter_if (req/wdata/clr in, gnt/Q/owner/valid/busy out).
module dff_bank_arbiter import dff_arb_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input logic CLK,
    input logic reset,
    dff_bank_arbiter_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    logic [1:0]       state;
    logic [IW-1:0]    ptr, win, pick;
    logic [CW-1:0]    cnt;
    logic             any_req;
    logic [WIDTH-1:0] wsel;
    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req(bus.req), .ptr(ptr), .winner(pick), .any_req(any_req)
    );
    // gnt decodes from state so an async reset drops it immediately.
    assign bus.gnt  = (state == GRANT) ? (NUM_REQ'(1) << win) : '0;
    assign bus.busy = (state == GRANT) || (state == HOLD);
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IW'(i)) wsel = bus.wdata[slice_lo(i, WIDTH) +: WIDTH];
    end
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            win       <= '0;
            cnt       <= '0;
            bus.Q     <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    win   <= pick;
                    state <= GRANT;
                end
                GRANT: begin
                    cnt   <= '0;
                    state <= (bus.req[win] && HOLD_CYCLES != 0) ? HOLD : IDLE;
                    // A dropped request aborts: no write and the pointer keeps its old value.
                    if (bus.req[win]) begin
                        ptr       <= win;
                        bus.Q     <= wsel;
                        bus.owner <= win;
                        bus.valid <= 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (HOLD_CYCLES != 0 && cnt == CW'(HOLD_CYCLES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Clear overrides any same-edge write; the FSM and pointer still advance.
            if (bus.clr) begin
                bus.Q     <= '0;
                bus.owner <= '0;
                bus.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed self-checking bench for dff_bank_arbiter (NUM_REQ=4, WIDTH=8, HOLD_CYCLES=2).
module tb_dff_bank_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    dff_bank_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus();
    dff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .CLK(clk), .reset(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == 4'b0 && n < 12);
        check(tag, bus.gnt, exp);
    endtask
    initial begin
        int g = 0;
        int last = 0;
        bus.req = 4'b0;
        bus.clr = 1'b0;
        bus.wdata = 32'h443322A5;
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt", bus.gnt, 0);
        check("rst_q", bus.Q, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_busy", bus.busy, 0);
        #9 rst_n = 1'b1;
        // single requester
        bus.req = 4'b0001;
        step();
        check("single_gnt", bus.gnt, 4'b0001);
        check("single_busy1", bus.busy, 1);
        check("single_q_early", bus.Q, 0);
        step();
        bus.req = 4'b0;
        check("single_q", bus.Q, 8'hA5);
        check("single_owner", bus.owner, 0);
        check("single_valid", bus.valid, 1);
        check("single_gnt_off", bus.gnt, 0);
        check("single_busy2", bus.busy, 1);
        step();
        check("single_busy3", bus.busy, 1);
        step();
        check("single_busy_end", bus.busy, 0);
        // fairness from reset with all requests held
        bus.wdata = 32'h44332211;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 40 && g < 5; c++) begin
            step();
            if (bus.gnt != 4'b0) begin
                check("fair_gnt", bus.gnt, 4'b0001 << (g % 4));
                if (g > 0) check("fair_gap", c - last, 4);
                last = c;
                step();
                c++;
                check("fair_q", bus.Q, 32'h11 * ((g % 4) + 1));
                g++;
            end
        end
        check("fair_count", g, 5);
        // wrap-around: set pointer to 2, then 0 must beat 1
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.req = 4'b0100;
        wait_gnt("wrap_setup", 4'b0100);
        step();
        bus.req = 4'b0011;
        wait_gnt("wrap_gnt0", 4'b0001);
        step();
        bus.req = 4'b0010;
        check("wrap_q0", bus.Q, 8'h11);
        wait_gnt("wrap_gnt1", 4'b0010);
        step();
        bus.req = 4'b0;
        check("wrap_q1", bus.Q, 8'h22);
        check("wrap_owner1", bus.owner, 1);
        // abort: request dropped during GRANT
        bus.req = 4'b0100;
        wait_gnt("abort_gnt", 4'b0100);
        bus.req = 4'b0;
        step();
        check("abort_busy", bus.busy, 0);
        check("abort_gnt_off", bus.gnt, 0);
        check("abort_q", bus.Q, 8'h22);
        check("abort_owner", bus.owner, 1);
        check("abort_valid", bus.valid, 1);
        bus.req = 4'b0110;
        wait_gnt("abort_ptr_kept", 4'b0100);
        step();
        bus.req = 4'b0;
        check("abort_next_q", bus.Q, 8'h33);
        check("abort_next_owner", bus.owner, 2);
        // clear colliding with a write
        bus.wdata = 32'h3C332211;
        bus.req = 4'b1000;
        wait_gnt("clr_gnt", 4'b1000);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        bus.req = 4'b1001;
        check("clr_q", bus.Q, 0);
        check("clr_valid", bus.valid, 0);
        check("clr_owner", bus.owner, 0);
        check("clr_busy", bus.busy, 1);
        wait_gnt("clr_skip", 4'b0001);
        step();
        bus.req = 4'b0;
        check("clr_after_q", bus.Q, 8'h11);
        check("clr_after_valid", bus.valid, 1);
        // async reset while in HOLD
        bus.req = 4'b0010;
        wait_gnt("hold_gnt", 4'b0010);
        step();
        bus.req = 4'b0;
        check("hold_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_q", bus.Q, 0);
        check("arst_valid", bus.valid, 0);
        check("arst_owner", bus.owner, 0);
        #1 rst_n = 1'b1;
        bus.req = 4'b1001;
        wait_gnt("arst_first", 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt_drop", bus.gnt, 0);
        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
